// File: rtl/img_buffer_writer.sv
// img_buffer_writer: writes an AXI-Stream-style video frame into an image RAM, in raster order.
module img_buffer_writer #(
  parameter int IMG_WIDTH  = 224,
  parameter int IMG_HEIGHT = 224,
  parameter int ADDR_W     = 16
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic              load_enable,
  input  logic [23:0]       s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tuser,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);
  localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
  typedef enum logic [1:0] {IDLE, SYNC, LOAD, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [ADDR_W-1:0] addr;
  logic accept, sof, bad, wr, col_end, row_end;
  assign accept  = s_tvalid & s_tready;
  assign col_end = col == CW'(IMG_WIDTH - 1);
  assign row_end = row == RW'(IMG_HEIGHT - 1);
  assign sof     = accept & s_tuser;
  // tlast must coincide exactly with the last column; an early SOF overrides this check
  assign bad     = accept & ~s_tuser & (state == LOAD) & (s_tlast != col_end);
  assign wr      = sof | (accept & (state == LOAD) & ~bad);
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = load_enable ? SYNC : IDLE;
      SYNC: nxt = !load_enable ? IDLE : sof ? LOAD : SYNC;
      LOAD: nxt = !load_enable ? IDLE : sof ? LOAD : bad ? SYNC :
                  (wr & col_end & row_end) ? DONE : LOAD;
      DONE: nxt = load_enable ? SYNC : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      addr       <= '0;
      s_tready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 24'h000000;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= nxt;
      s_tready   <= (nxt == SYNC) || (nxt == LOAD);
      busy       <= nxt == LOAD;
      frame_done <= nxt == DONE;
      frame_err  <= load_enable & (state == LOAD) & (sof | bad);
      wr_en      <= wr;
      if (wr) begin
        wr_addr <= sof ? '0 : addr;
        wr_data <= s_tdata;
      end
      if (sof) begin
        col  <= CW'(1);
        row  <= '0;
        addr <= ADDR_W'(1);
      end else if (wr) begin
        col  <= col_end ? '0 : col + CW'(1);
        row  <= col_end ? row + RW'(1) : row;
        addr <= addr + ADDR_W'(1);
      end
    end
  end
endmodule
